// File: rtl/multimodal_spatial_encoder_pkg.sv
// Shared types and elaboration helpers for the HDC spatial encoder.
package hdc_se_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  localparam int MAX_CH    = 255;
  localparam int MAX_MODES = 32;

  // Channel-count vector widened to a fixed size so helpers take one type.
  typedef logic [8*MAX_MODES-1:0] counts_t;

  // Accumulator width: largest vote total is N+1 (even N plus tie vote).
  function automatic int cnt_width(input int max_ch);
    return $clog2(max_ch + 2);
  endfunction

  // 8-bit channel count of mode m.
  function automatic logic [7:0] ch_of(input counts_t counts, input int m);
    return counts[8*m +: 8];
  endfunction

  // Largest channel count over the first n modes, clamped to MAX_CH.
  function automatic int max_of(input counts_t counts, input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) begin
      if (int'(counts[8*k +: 8]) > r) r = int'(counts[8*k +: 8]);
    end
    return (r > MAX_CH) ? MAX_CH : r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multimodal_spatial_encoder_if.sv
// Data-in and hypervector-out handshake bundle of the spatial encoder.
interface multimodal_spatial_encoder_if #(
  parameter int FOLD_WIDTH = 2000
);
  import hdc_se_pkg::*;

  logic                  din_valid;
  logic                  din_ready;
  logic [FOLD_WIDTH-1:0] im;
  logic [FOLD_WIDTH-1:0] projm;
  logic                  hvout_valid;
  logic                  hvout_ready;
  logic [FOLD_WIDTH-1:0] hvout;

  // Encoder side.
  modport slave (
    input  din_valid, im, projm, hvout_ready,
    output din_ready, hvout_valid, hvout
  );

  // Generator / fuser side.
  modport master (
    output din_valid, im, projm, hvout_ready,
    input  din_ready, hvout_valid, hvout
  );
endinterface

// File: rtl/multimodal_spatial_encoder_bit_counter.sv
// One-bit vote accumulator with majority compare against a threshold.
module se_bit_counter
  import hdc_se_pkg::*;
#(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          vote,
  input  logic          tie_en,
  input  logic          tie,
  input  logic [CW-1:0] thr,
  output logic          maj
);

  logic [CW-1:0] r_acc;

  // Accumulate the bound-bit vote plus the optional tie-break vote.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + CW'(vote) + CW'(tie_en & tie);
    end else begin
      r_acc <= r_acc;
    end
  end

  assign maj = (r_acc > thr);

endmodule

// File: rtl/multimodal_spatial_encoder.sv
// Spatial encoder: binds im^projm per channel and bundles each modality
// into a majority hypervector, fold by fold, with valid/ready on both sides.
module multimodal_spatial_encoder
  import hdc_se_pkg::*;
#(
  parameter int                     NUM_MODES  = 3,
  parameter logic [8*NUM_MODES-1:0] CH_COUNTS  = {8'd105, 8'd77, 8'd32},
  parameter int                     NUM_FOLDS  = 1,
  parameter int                     FOLD_WIDTH = 2000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic [7:0]                        ch_idx,
  output logic [idx_width(NUM_MODES)-1:0]   mode_idx,
  output logic [idx_width(NUM_FOLDS)-1:0]   fold_idx,
  output logic                              done,
  multimodal_spatial_encoder_if.slave       bus
);

  localparam int MW = idx_width(NUM_MODES);
  localparam int FI = idx_width(NUM_FOLDS);
  localparam int CW = cnt_width(max_of(counts_t'(CH_COUNTS), NUM_MODES));
  localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);
  localparam logic [FI-1:0] LAST_FOLD = FI'(NUM_FOLDS - 1);

  state_e                r_state;
  state_e                w_next_state;
  logic [7:0]            r_ch_idx;
  logic [MW-1:0]         r_mode_idx;
  logic [FI-1:0]         r_fold_idx;
  logic [FOLD_WIDTH-1:0] r_first_hv;
  logic                  r_done;

  logic [7:0]            w_n;
  logic                  w_last;
  logic                  w_tie_en;
  logic                  w_fire_in;
  logic                  w_fire_out;
  logic                  w_final;
  logic                  w_clr;
  logic [CW-1:0]         w_thr;
  logic [FOLD_WIDTH-1:0] w_b;
  logic [FOLD_WIDTH-1:0] w_maj;

  assign w_n        = ch_of(counts_t'(CH_COUNTS), int'(r_mode_idx));
  assign w_last     = (r_ch_idx == (w_n - 8'd1));
  // Even channel counts get one extra vote so a tie can never occur.
  assign w_tie_en   = w_last & ~w_n[0];
  // floor(Neff/2) equals floor(N/2) for both odd and even N.
  assign w_thr      = CW'(w_n >> 1);
  assign w_b        = bus.im ^ bus.projm;
  assign w_fire_in  = (r_state == ST_ACCUM) & bus.din_valid;
  assign w_fire_out = (r_state == ST_EMIT) & bus.hvout_ready;
  assign w_final    = (r_mode_idx == LAST_MODE) & (r_fold_idx == LAST_FOLD);
  assign w_clr      = ((r_state == ST_IDLE) & start) | w_fire_out;

  for (genvar gi = 0; gi < FOLD_WIDTH; gi++) begin : g_bit
    se_bit_counter #(.CW(CW)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_clr),
      .en     (w_fire_in),
      .vote   (w_b[gi]),
      .tie_en (w_tie_en),
      .tie    (r_first_hv[gi] ^ w_b[gi]),
      .thr    (w_thr),
      .maj    (w_maj[gi])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_ACCUM;
        else       w_next_state = ST_IDLE;
      end
      ST_ACCUM: begin
        if (w_fire_in && w_last) w_next_state = ST_EMIT;
        else                     w_next_state = ST_ACCUM;
      end
      ST_EMIT: begin
        if (w_fire_out) w_next_state = w_final ? ST_IDLE : ST_ACCUM;
        else            w_next_state = ST_EMIT;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Channel/mode/fold counters, first-beat capture and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch_idx   <= 8'd0;
      r_mode_idx <= '0;
      r_fold_idx <= '0;
      r_first_hv <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ch_idx   <= 8'd0;
            r_mode_idx <= '0;
            r_fold_idx <= '0;
          end
        end
        ST_ACCUM: begin
          if (w_fire_in) begin
            r_ch_idx <= r_ch_idx + 8'd1;
            if (r_ch_idx == 8'd0) r_first_hv <= w_b;
          end
        end
        ST_EMIT: begin
          if (w_fire_out) begin
            r_ch_idx <= 8'd0;
            if (r_mode_idx != LAST_MODE) begin
              r_mode_idx <= r_mode_idx + MW'(1);
            end else begin
              r_mode_idx <= '0;
              if (r_fold_idx != LAST_FOLD) begin
                r_fold_idx <= r_fold_idx + FI'(1);
              end else begin
                r_fold_idx <= '0;
                r_done     <= 1'b1;
              end
            end
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign busy            = (r_state != ST_IDLE);
  assign bus.din_ready   = (r_state == ST_ACCUM);
  assign bus.hvout_valid = (r_state == ST_EMIT);
  assign bus.hvout       = (r_state == ST_EMIT) ? w_maj : '0;
  assign ch_idx          = r_ch_idx;
  assign mode_idx        = r_mode_idx;
  assign fold_idx        = r_fold_idx;
  assign done            = r_done;

endmodule

// File: tb/tb_multimodal_spatial_encoder.sv
// Directed + scoreboard bench: an 8-bit three-mode encoder (N = 3, 2, 4)
// for exact majority/tie cases, flow control and reset, and a default-count
// four-fold 500-bit encoder checked against a vote-counting reference model.
module tb_multimodal_spatial_encoder;
  import hdc_se_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_s, start_f;
  logic       busy_s, done_s, busy_f, done_f;
  logic [7:0] ch_s, ch_f;
  logic [1:0] mode_s, mode_f;
  logic [0:0] fold_s;
  logic [1:0] fold_f;

  multimodal_spatial_encoder_if #(.FOLD_WIDTH(8))   sif ();
  multimodal_spatial_encoder_if #(.FOLD_WIDTH(500)) fif ();

  multimodal_spatial_encoder #(
    .NUM_MODES(3), .CH_COUNTS({8'd4, 8'd2, 8'd3}), .NUM_FOLDS(1), .FOLD_WIDTH(8)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .ch_idx(ch_s),
    .mode_idx(mode_s), .fold_idx(fold_s), .done(done_s), .bus(sif.slave)
  );

  multimodal_spatial_encoder #(
    .NUM_MODES(3), .CH_COUNTS({8'd105, 8'd77, 8'd32}), .NUM_FOLDS(4), .FOLD_WIDTH(500)
  ) u_full (
    .clk(clk), .rst_n(rst_n), .start(start_f), .busy(busy_f), .ch_idx(ch_f),
    .mode_idx(mode_f), .fold_idx(fold_f), .done(done_f), .bus(fif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   q_s[$];
  logic [499:0] q_f[$];
  int           q_t[$];

  logic [7:0]   tab_b [0:8] = '{8'hF0, 8'hCC, 8'hAA, 8'hF0, 8'h0F, 8'hF0, 8'hCC, 8'hAA, 8'h0F};
  int           tab_n [0:2] = '{3, 2, 4};
  logic [7:0]   tab_e [0:2] = '{8'hE8, 8'hFF, 8'hEE};
  int           cnt_f [0:2] = '{32, 77, 105};
  logic [499:0] bf [0:104];
  logic [499:0] pf [0:104];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [499:0] rnd500();
    logic [511:0] t;
    for (int k = 0; k < 16; k++) t[32*k +: 32] = $urandom;
    return t[499:0];
  endfunction

  task automatic send_s(input logic [7:0] d, input logic [7:0] p, input int gap);
    logic ok;
    int   n;
    repeat (gap) tick();
    sif.im = d; sif.projm = p; sif.din_valid = 1'b1; n = 0;
    do begin ok = sif.din_ready; tick(); n++; end while (!ok && n < 20);
    sif.din_valid = 1'b0;
    chk("s_accept", 512'(ok), 512'(1'b1));
  endtask

  task automatic recv_s();
    int n;
    logic [7:0] e;
    n = 0;
    while (!sif.hvout_valid && n < 20) begin tick(); n++; end
    chk("s_hv_valid", 512'(sif.hvout_valid), 512'(1'b1));
    e = q_s.pop_front();
    chk("s_hvout", 512'(sif.hvout), 512'(e));
    sif.hvout_ready = 1'b1; tick(); sif.hvout_ready = 1'b0;
  endtask

  task automatic send_f(input logic [499:0] d, input logic [499:0] p);
    logic ok;
    int   n;
    fif.im = d; fif.projm = p; fif.din_valid = 1'b1; n = 0;
    do begin ok = fif.din_ready; tick(); n++; end while (!ok && n < 20);
    fif.din_valid = 1'b0;
    chk("f_accept", 512'(ok), 512'(1'b1));
  endtask

  task automatic recv_f();
    int n;
    n = 0;
    while (!fif.hvout_valid && n < 20) begin tick(); n++; end
    chk("f_hv_valid", 512'(fif.hvout_valid), 512'(1'b1));
    chk("f_hvout", 512'(fif.hvout), 512'(q_f.pop_front()));
    chk("f_order", 512'({fold_f, mode_f}), 512'(q_t.pop_front()));
    fif.hvout_ready = 1'b1; tick(); fif.hvout_ready = 1'b0;
  endtask

  task automatic chk_small_zero(input string tag);
    chk(tag, 512'({busy_s, sif.din_ready, sif.hvout_valid, done_s, sif.hvout, ch_s, mode_s, fold_s}), 512'(0));
  endtask

  initial begin
    logic [7:0]   mask;
    logic [499:0] e;
    int           k, ones;

    rst_n = 1'b0; start_s = 1'b0; start_f = 1'b0;
    sif.din_valid = 1'b0; sif.im = '0; sif.projm = '0; sif.hvout_ready = 1'b0;
    fif.din_valid = 1'b0; fif.im = '0; fif.projm = '0; fif.hvout_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_small_zero("reset_outs");
    chk("full_idle", 512'({busy_f, fif.din_ready, fif.hvout_valid, done_f, ch_f}), 512'(0));

    // Small encoder: two samples, second with random gaps, masks and a stall.
    start_s = 1'b1; tick(); start_s = 1'b0;
    chk("start_busy", 512'({busy_s, sif.din_ready}), 512'(2'b11));
    for (int s = 0; s < 2; s++) begin
      k = 0;
      for (int m = 0; m < 3; m++) begin
        q_s.push_back(tab_e[m]);
        chk("s_mode", 512'(mode_s), 512'(m));
        for (int c = 0; c < tab_n[m]; c++) begin
          if (s == 0 && m == 0 && c == 1) begin
            start_s = 1'b1; tick(); start_s = 1'b0;
            chk("start_ignored", 512'({ch_s, mode_s, busy_s}), 512'({8'd1, 2'd0, 1'b1}));
          end
          chk("s_ch", 512'(ch_s), 512'(c));
          mask = (s == 1) ? 8'($urandom) : 8'h00;
          send_s(tab_b[k] ^ mask, mask, (s == 1) ? int'($urandom_range(0, 3)) : 0);
          k++;
        end
        chk("s_valid_lat", 512'({sif.hvout_valid, sif.din_ready}), 512'(2'b10));
        if (s == 1 && m == 2) begin
          sif.din_valid = 1'b1;
          repeat (5) begin
            tick();
            chk("stall_hv", 512'(sif.hvout), 512'(tab_e[m]));
            chk("stall_ctl", 512'({sif.hvout_valid, sif.din_ready, mode_s}), 512'({1'b1, 1'b0, 2'd2}));
          end
          sif.din_valid = 1'b0;
        end
        recv_s();
        if (m < 2) chk("s_no_done", 512'({done_s, busy_s}), 512'(2'b01));
      end
      chk("s_done", 512'({done_s, busy_s}), 512'(2'b10));
      if (s == 0) begin
        start_s = 1'b1; tick(); start_s = 1'b0;
        chk("start_in_done", 512'({busy_s, ch_s, mode_s, fold_s}), 512'({1'b1, 8'd0, 2'd0, 1'b0}));
      end else begin
        tick();
        chk("s_done_pulse", 512'({done_s, busy_s}), 512'(2'b00));
      end
    end

    // Reset in the middle of ACCUM discards partial votes.
    start_s = 1'b1; tick(); start_s = 1'b0;
    send_s(8'hF0, 8'h00, 0);
    send_s(8'h3C, 8'h00, 0);
    rst_n = 1'b0;
    repeat (3) begin tick(); chk_small_zero("mid_reset"); end
    rst_n = 1'b1;
    tick();
    chk_small_zero("post_reset");
    start_s = 1'b1; tick(); start_s = 1'b0;
    chk("restart", 512'({busy_s, ch_s, mode_s, fold_s}), 512'({1'b1, 8'd0, 2'd0, 1'b0}));
    q_s.push_back(8'hE8);
    send_s(8'hF0, 8'h00, 0);
    send_s(8'hCC, 8'h00, 0);
    send_s(8'hAA, 8'h00, 0);
    recv_s();

    // Full encoder: 4 folds x 3 modes of random data against the vote model.
    start_f = 1'b1; tick(); start_f = 1'b0;
    for (int f = 0; f < 4; f++) begin
      for (int m = 0; m < 3; m++) begin
        for (int c = 0; c < cnt_f[m]; c++) begin
          bf[c] = rnd500();
          pf[c] = rnd500();
        end
        for (int i = 0; i < 500; i++) begin
          ones = 0;
          for (int c = 0; c < cnt_f[m]; c++) ones += int'(bf[c][i]);
          if (2 * ones > cnt_f[m])      e[i] = 1'b1;
          else if (2 * ones < cnt_f[m]) e[i] = 1'b0;
          else                          e[i] = bf[0][i] ^ bf[cnt_f[m]-1][i];
        end
        q_f.push_back(e);
        q_t.push_back(f * 4 + m);
        for (int c = 0; c < cnt_f[m]; c++) begin
          chk("f_ch", 512'(ch_f), 512'(c));
          send_f(bf[c] ^ pf[c], pf[c]);
        end
        recv_f();
        if (!(f == 3 && m == 2)) chk("f_no_done", 512'({done_f, busy_f}), 512'(2'b01));
      end
    end
    chk("f_done", 512'({done_f, busy_f}), 512'(2'b10));
    tick();
    chk("f_done_pulse", 512'({done_f, busy_f}), 512'(2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
